// File: rtl/toggle_dec_pkg.sv
`default_nettype none
// ============================================================================
// Module : toggle_dec_pkg
// Brief  : Shared types and helpers for toggle_event_decoder.
// Rev    : 1.0  initial release
// ============================================================================
package toggle_dec_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_QUAL = 1'b1
    } state_t;

    // Holds sample counts for filter lengths up to 15
    localparam int c_QCNT_W = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_event_decoder_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module : evt_fifo
// Brief  : Synchronous FIFO with registered head word and valid flag.
// Rev    : 1.0  initial release
// ============================================================================
module evt_fifo
    import toggle_dec_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full
);

    localparam int c_AW = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr;
    logic [c_AW:0]    r_rd;
    logic [c_AW:0]    w_wr_n;
    logic [c_AW:0]    w_rd_n;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;
    logic [WIDTH-1:0] w_head_n;
    logic             r_valid;
    logic [WIDTH-1:0] r_dout;

    assign w_empty   = (r_wr == r_rd);
    assign w_full    = (r_wr[c_AW] != r_rd[c_AW]) &&
                       (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign w_wr_n    = r_wr + {{c_AW{1'b0}}, w_do_push};
    assign w_rd_n    = r_rd + {{c_AW{1'b0}}, w_do_pop};

    // The word landing this edge bypasses memory when it becomes the head
    always_comb begin
        w_head_n = r_mem[w_rd_n[c_AW-1:0]];
        if (w_do_push && (w_rd_n == r_wr)) begin
            w_head_n = i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr[c_AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_wr    <= w_wr_n;
            r_rd    <= w_rd_n;
            r_valid <= (w_wr_n != w_rd_n);
            r_dout  <= w_head_n;
        end
    end

    assign o_valid = r_valid;
    assign o_dout  = r_dout;
    assign o_full  = w_full;

endmodule
`default_nettype wire

// File: rtl/toggle_event_decoder.sv
`default_nettype none
// ============================================================================
// Module : toggle_event_decoder
// Brief  : Glitch-filtered toggle-to-pulse decoder with event counter and
//          sequence-number buffer. TOGGLE_DEC_SYNC_EN adds a 2-flop input
//          synchronizer.
// Rev    : 1.0  initial release
// ============================================================================
module toggle_event_decoder
    import toggle_dec_pkg::*;
#(
    parameter int FILT_CYCLES = 2,
    parameter int CNT_W       = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             T_in,
    output logic             level,
    output logic             pulse,
    output logic             glitch,
    output logic [CNT_W-1:0] total,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_seq,
    output logic             overflow
);

    localparam logic [c_QCNT_W-1:0] c_FILT = c_QCNT_W'(FILT_CYCLES);

    logic                w_s_src;
    logic                r_s;
    state_t              r_state;
    state_t              w_state_n;
    logic [c_QCNT_W-1:0] r_qcnt;
    logic [c_QCNT_W-1:0] w_qcnt_n;
    logic [c_QCNT_W-1:0] w_qcnt_inc;
    logic                w_accept;
    logic                w_glitch;
    logic                r_level;
    logic                r_pulse;
    logic                r_glitch;
    logic [CNT_W-1:0]    r_total;
    logic [CNT_W-1:0]    w_total_n;
    logic                r_overflow;
    logic                w_full;
    logic                w_drop;

`ifdef TOGGLE_DEC_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= T_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s_src = r_sync2;
`else
    assign w_s_src = T_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s <= 1'b0;
        end else begin
            r_s <= w_s_src;
        end
    end

    // r_qcnt counts qualifying samples already seen; this sample is one more
    assign w_qcnt_inc = r_qcnt + c_QCNT_W'(1);

    always_comb begin
        w_state_n = r_state;
        w_qcnt_n  = r_qcnt;
        w_accept  = 1'b0;
        w_glitch  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_s != r_level) begin
                    if (c_FILT == c_QCNT_W'(1)) begin
                        w_accept = 1'b1;
                        w_qcnt_n = '0;
                    end else begin
                        w_state_n = ST_QUAL;
                        w_qcnt_n  = c_QCNT_W'(1);
                    end
                end
            end
            ST_QUAL: begin
                if (r_s == r_level) begin
                    w_glitch  = 1'b1;
                    w_state_n = ST_IDLE;
                    w_qcnt_n  = '0;
                end else if (w_qcnt_inc == c_FILT) begin
                    w_accept  = 1'b1;
                    w_state_n = ST_IDLE;
                    w_qcnt_n  = '0;
                end else begin
                    w_qcnt_n  = w_qcnt_inc;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_qcnt_n  = '0;
            end
        endcase
    end

    assign w_total_n = r_total + CNT_W'(1);
    assign w_drop    = w_accept && w_full && !(evt_valid && evt_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_qcnt     <= '0;
            r_level    <= 1'b0;
            r_pulse    <= 1'b0;
            r_glitch   <= 1'b0;
            r_total    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_qcnt   <= w_qcnt_n;
            r_pulse  <= w_accept;
            r_glitch <= w_glitch;
            if (w_accept) begin
                r_level <= ~r_level;
                r_total <= w_total_n;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    evt_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_accept),
        .i_din   (w_total_n),
        .i_pop   (evt_ready),
        .o_valid (evt_valid),
        .o_dout  (evt_seq),
        .o_full  (w_full)
    );

    assign level    = r_level;
    assign pulse    = r_pulse;
    assign glitch   = r_glitch;
    assign total    = r_total;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_toggle_event_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_toggle_event_decoder
// Brief  : Self-checking bench: vector table, directed sequences, random run.
// Rev    : 1.0  initial release
// ============================================================================
module tb_toggle_event_decoder;

    localparam int FILT  = 2;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       t_in;
    logic       level;
    logic       pulse;
    logic       glitch;
    logic [7:0] total;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_seq;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    toggle_event_decoder #(
        .FILT_CYCLES (FILT),
        .CNT_W       (8),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .T_in      (t_in),
        .level     (level),
        .pulse     (pulse),
        .glitch    (glitch),
        .total     (total),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_seq   (evt_seq),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: run-length of samples disagreeing with the accepted level
    logic       m_s;
    logic       m_level;
    logic       m_pulse;
    logic       m_glitch;
    logic       m_ovf;
    logic [7:0] m_total;
    int         m_run;
    logic [7:0] m_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_edge();
        logic obs;
        logic acc;
        logic pop;
        logic was_full;
        if (reset) begin
            m_s = 0; m_level = 0; m_pulse = 0; m_glitch = 0;
            m_ovf = 0; m_total = 0; m_run = 0; m_q.delete();
        end else begin
            obs      = m_s;
            m_s      = t_in;
            acc      = 1'b0;
            m_glitch = 1'b0;
            if (obs != m_level) begin
                m_run++;
                if (m_run == FILT) begin
                    acc   = 1'b1;
                    m_run = 0;
                end
            end else begin
                m_glitch = (m_run > 0);
                m_run    = 0;
            end
            m_pulse  = acc;
            pop      = (m_q.size() > 0) && evt_ready;
            was_full = (m_q.size() == DEPTH);
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                m_level = ~m_level;
                m_total = m_total + 8'd1;
                if (!was_full || pop) m_q.push_back(m_total);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic model_check();
        logic [31:0] act;
        logic [31:0] exp;
        logic        ev;
        logic [7:0]  es;
        ev  = (m_q.size() > 0);
        es  = ev ? m_q[0] : 8'd0;
        exp = {11'd0, m_level, m_pulse, m_glitch, m_ovf, ev, m_total, es};
        act = {11'd0, level, pulse, glitch, overflow, evt_valid, total,
               (evt_valid ? evt_seq : 8'd0)};
        chk("model", act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    task automatic do_reset(input logic rdy);
        reset = 1'b1; t_in = 1'b0; evt_ready = rdy;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic flip(input int gap);
        t_in = ~t_in;
        repeat (gap) tick();
    endtask

    typedef struct {
        logic       rst;
        logic       t;
        logic       rdy;
        logic       lvl;
        logic       pls;
        logic       gl;
        logic [7:0] tot;
        logic       vld;
        logic       chk_seq;
        logic [7:0] seq;
    } vec_t;

    vec_t tbl[18];

    initial begin
        // rst t rdy | lvl pls gl tot vld chk_seq seq
        tbl[0]  = '{1, 0, 1, 0, 0, 0, 8'd0, 0, 1, 8'd0};
        tbl[1]  = '{0, 1, 1, 0, 0, 0, 8'd0, 0, 0, 8'd0};
        tbl[2]  = '{0, 1, 1, 0, 0, 0, 8'd0, 0, 0, 8'd0};
        tbl[3]  = '{0, 1, 1, 1, 1, 0, 8'd1, 1, 1, 8'd1};
        tbl[4]  = '{0, 1, 1, 1, 0, 0, 8'd1, 0, 0, 8'd0};
        tbl[5]  = '{0, 1, 1, 1, 0, 0, 8'd1, 0, 0, 8'd0};
        tbl[6]  = '{1, 0, 1, 0, 0, 0, 8'd0, 0, 1, 8'd0};
        tbl[7]  = '{0, 1, 1, 0, 0, 0, 8'd0, 0, 0, 8'd0};
        tbl[8]  = '{0, 0, 1, 0, 0, 0, 8'd0, 0, 0, 8'd0};
        tbl[9]  = '{0, 0, 1, 0, 0, 1, 8'd0, 0, 0, 8'd0};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 8'd0, 0, 0, 8'd0};
        tbl[11] = '{0, 1, 1, 0, 0, 0, 8'd0, 0, 0, 8'd0};
        tbl[12] = '{0, 1, 1, 0, 0, 0, 8'd0, 0, 0, 8'd0};
        tbl[13] = '{1, 1, 1, 0, 0, 0, 8'd0, 0, 1, 8'd0};
        tbl[14] = '{0, 1, 1, 0, 0, 0, 8'd0, 0, 0, 8'd0};
        tbl[15] = '{0, 1, 1, 0, 0, 0, 8'd0, 0, 0, 8'd0};
        tbl[16] = '{0, 1, 1, 1, 1, 0, 8'd1, 1, 1, 8'd1};
        tbl[17] = '{0, 1, 1, 1, 0, 0, 8'd1, 0, 0, 8'd0};

        reset = 1'b1; t_in = 1'b0; evt_ready = 1'b1;
        m_s = 0; m_level = 0; m_pulse = 0; m_glitch = 0;
        m_ovf = 0; m_total = 0; m_run = 0;

        for (int i = 0; i < 18; i++) begin
            reset = tbl[i].rst; t_in = tbl[i].t; evt_ready = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d", i),
                {15'd0, level, pulse, glitch, overflow, evt_valid, total,
                 (tbl[i].chk_seq ? evt_seq : 8'd0)},
                {15'd0, tbl[i].lvl, tbl[i].pls, tbl[i].gl, 1'b0, tbl[i].vld, tbl[i].tot,
                 (tbl[i].chk_seq ? tbl[i].seq : 8'd0)});
        end

        // Six flips with consumer stalled: 1..4 buffered, 5 and 6 dropped
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) flip(4);
        chk("six_total", 32'(total), 32'd6);
        chk("six_ovf", 32'(overflow), 32'd1);
        chk("six_level", 32'(level), 32'd0);
        evt_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain_valid%0d", k), 32'(evt_valid), 32'd1);
            chk($sformatf("drain_seq%0d", k), 32'(evt_seq), 32'(k));
            tick();
        end
        chk("drain_empty", 32'(evt_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full buffer, accept coinciding with a pop: nothing lost
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) flip(4);
        chk("full_seq", 32'(evt_seq), 32'd1);
        t_in = ~t_in;
        tick();
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("pp_pulse", 32'(pulse), 32'd1);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_total", 32'(total), 32'd5);
        chk("pp_head", 32'(evt_seq), 32'd2);
        evt_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("pp_drain%0d", k), 32'(evt_seq), 32'(k));
            tick();
        end
        chk("pp_empty", 32'(evt_valid), 32'd0);

        // 256 minimum-spaced flips: counter and sequence numbers wrap
        do_reset(1'b1);
        for (int i = 1; i <= 256; i++) begin
            flip(FILT + 1);
            if (i >= 254) begin
                chk($sformatf("wrap_total%0d", i), 32'(total), 32'(i % 256));
                chk($sformatf("wrap_seq%0d", i), 32'({evt_valid, evt_seq}),
                    32'({1'b1, 8'(i % 256)}));
            end
        end
        chk("wrap_ovf", 32'(overflow), 32'd0);

        // Random toggling, stalls and occasional resets against the model
        do_reset(1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) t_in = ~t_in;
            evt_ready = 1'($urandom_range(0, 1));
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
